// File: rtl/ps2_keyboard_rx_fifo_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: prefix codes,
// receiver state encoding and the buffered key-word layout.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int unsigned BRK_BIT = 9;
    localparam int unsigned EXT_BIT = 8;
    localparam int unsigned KEY_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Field order matches BRK_BIT/EXT_BIT: {break, extended, code}
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_word_t;

endpackage

// File: rtl/ps2_keyboard_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO pop/clear controls, head word and status.
interface ps2_keyboard_rx_fifo_if;

    logic              rd_en;
    logic              clr_err;
    ps2_pkg::key_word_t data_out;
    logic              ready;
    logic              overflow;
    logic              parity_err;
    logic              frame_err;

    modport master (
        output rd_en, clr_err,
        input  data_out, ready, overflow, parity_err, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output data_out, ready, overflow, parity_err, frame_err
    );

endinterface

// File: rtl/ps2_keyboard_rx_fifo_sync_filter.sv
// Synchronises raw ps2_clk/ps2_data, de-glitches the clock with a run-length filter
// and emits a one-cycle strobe with the aligned data sample on each filtered falling edge.
module ps2_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic data_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [FILTER_LEN-1:0]  hist_q;
    logic [FILTER_LEN-1:0]  hist_d;
    logic                   filt_q;
    logic                   filt_d;
    logic                   fall_q;
    logic                   data_q;

    // Filtered clock only moves once the last FILTER_LEN samples all agree
    always_comb begin
        hist_d = {hist_q[FILTER_LEN-2:0], clk_sync_q[SYNC_STAGES-1]};
        filt_d = filt_q;
        if (hist_d == '0) begin
            filt_d = 1'b0;
        end else if (hist_d == '1) begin
            filt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            hist_q      <= hist_d;
            filt_q      <= filt_d;
            fall_q      <= filt_q & ~filt_d;
            data_q      <= data_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_o = data_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// {break, extended, code} key words and buffers them in a show-ahead FIFO.
module ps2_keyboard_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_keyboard_rx_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    logic             data_s;
    logic             fall_s;

    ps2_state_e       state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             brk_q;
    logic             ext_q;
    logic             good_q;
    logic [7:0]       code_q;
    logic             perr_q;
    logic             ferr_q;
    logic             par_ok_c;

    key_word_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    key_word_t        data_q, data_d;
    logic             ready_q;
    logic             ovf_q, ovf_d;
    logic             push_c, pop_c, full_c, wr_ok_c, drop_c;
    key_word_t        wdata_c;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .data_o     (data_s),
        .fall_o     (fall_s)
    );

    assign par_ok_c = ^shift_q ^ par_q;

    // Frame FSM, timeout supervisor and prefix decoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            good_q    <= 1'b0;
            code_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            good_q <= 1'b0;

            if (good_q) begin
                if (code_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (code_q == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                end
            end

            if (state_q == ST_IDLE || fall_s) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (fall_s) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= data_s;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (data_s && par_ok_c) begin
                            good_q <= 1'b1;
                            code_q <= shift_q;
                        end else begin
                            ferr_q <= ~data_s;
                            perr_q <= ~par_ok_c;
                            brk_q  <= 1'b0;
                            ext_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_q <= ST_IDLE;
                ferr_q  <= 1'b1;
                brk_q   <= 1'b0;
                ext_q   <= 1'b0;
            end
        end
    end

    // FIFO control; a pop frees the slot a simultaneous push needs even when full
    always_comb begin
        push_c  = good_q && (code_q != PS2_EXT) && (code_q != PS2_BRK);
        wdata_c = '{brk: brk_q, ext: ext_q, code: code_q};
        pop_c   = bus.rd_en && (count_q != '0);
        full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        wr_ok_c = push_c && (!full_c || pop_c);
        drop_c  = push_c && full_c && !pop_c;

        rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = wr_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(wr_ok_c) - CNT_W'(pop_c);
        ovf_d    = (ovf_q && !bus.clr_err) || drop_c;

        data_d = '0;
        if (count_d != '0) begin
            if (wr_ok_c && rd_ptr_d == wr_ptr_q) begin
                data_d = wdata_c;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            ready_q  <= (count_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.ready      = ready_q;
    assign bus.overflow   = ovf_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Directed bench for ps2_keyboard_rx_fifo: drives PS/2 frames and checks outputs
// every cycle against a queue-based key-word model.
module tb_ps2_keyboard_rx_fifo;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_keyboard_rx_fifo_if bus ();

    ps2_keyboard_rx_fifo #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] mq [$];
    logic m_ovf = 1'b0;
    logic m_brk = 1'b0;
    logic m_ext = 1'b0;
    int   exp_perr = 0, exp_ferr = 0;
    int   got_perr = 0, got_ferr = 0;
    bit   chk_en = 1'b0;
    logic prev_p = 1'b0, prev_f = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of the visible FIFO state against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(bus.ready), 32'(mq.size() != 0));
            check("data_out", 32'(bus.data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
        if (!rst) begin
            check("pulse_width", 32'((bus.parity_err & prev_p) | (bus.frame_err & prev_f)), 32'd0);
        end
        if (bus.parity_err) got_perr++;
        if (bus.frame_err)  got_ferr++;
        prev_p = bus.parity_err;
        prev_f = bus.frame_err;
    end

    // Key-word rules applied at the end of each received frame
    task automatic model_frame(input logic [7:0] code, input bit good);
        if (!good) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back({m_brk, m_ext, code});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #30 ps2_clk = 1'b0;
        #40 ps2_clk = 1'b1;
        #30;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        logic [10:0] fr;
        fr = {~bad_stop, ~(^code) ^ bad_par, code, 1'b0};
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        if (bad_par)  exp_perr++;
        if (bad_stop) exp_ferr++;
        model_frame(code, !bad_par && !bad_stop);
        chk_en = 1'b1;
    endtask

    task automatic pop();
        @(posedge clk);
        #1 bus.rd_en = 1'b1;
        @(posedge clk);
        #1 bus.rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_parity_cnt"}, 32'(got_perr), 32'(exp_perr));
        check({tag, "_frame_cnt"},  32'(got_ferr), 32'(exp_ferr));
    endtask

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_perr", 32'(bus.parity_err), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(posedge clk);

        // 1: break prefix folds into 10'h21A, pop empties, pop on empty is harmless
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1A, 0, 0);
        #1;
        check("s1_word", 32'(bus.data_out), 32'h21A);
        check("s1_ready", 32'(bus.ready), 32'd1);
        pop();
        #1;
        check("s1_empty", 32'(bus.ready), 32'd0);
        check("s1_zero", 32'(bus.data_out), 32'd0);
        pop();
        repeat (3) @(posedge clk);

        // 2: extended break then plain make, in order
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h1C, 0, 0);
        #1;
        check("s2_first", 32'(bus.data_out), 32'h375);
        pop();
        #1;
        check("s2_second", 32'(bus.data_out), 32'h01C);
        pop();
        check_pulses("s2");

        // 3: bad parity dropped; bad stop clears a pending break prefix
        send_frame(8'h1C, 1, 0);
        check_pulses("s3a");
        send_frame(8'h29, 0, 0);
        #1;
        check("s3_word", 32'(bus.data_out), 32'h029);
        pop();
        send_frame(8'hF0, 0, 0);
        send_frame(8'h33, 0, 1);
        send_frame(8'h29, 0, 0);
        #1;
        check("s3_noprefix", 32'(bus.data_out), 32'h029);
        pop();
        check_pulses("s3b");

        // 4: ninth word overflows; drain and clear
        for (int i = 0; i < 9; i++) send_frame(8'h1C, 0, 0);
        #1;
        check("s4_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("s4_pop_word", 32'(bus.data_out), 32'h01C);
            pop();
        end
        #1;
        check("s4_empty", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1 bus.clr_err = 1'b1;
        @(posedge clk);
        #1 bus.clr_err = 1'b0;
        m_ovf = 1'b0;
        #1;
        check("s4_clr", 32'(bus.overflow), 32'd0);

        // 5: truncated frame times out
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        repeat (250) @(posedge clk);
        exp_ferr++;
        model_frame(8'h00, 0);
        chk_en = 1'b1;
        check("s5_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check_pulses("s5");
        send_frame(8'h29, 0, 0);
        #1;
        check("s5_word", 32'(bus.data_out), 32'h029);
        pop();

        // 6: short glitch ignored; reset mid-frame abandons frame and FIFO
        @(posedge clk);
        #2 ps2_clk = 1'b0;
        #20 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        check("s6_glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check_pulses("s6a");
        send_frame(8'h29, 0, 0);
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("s6_rst_ready", 32'(bus.ready), 32'd0);
        check("s6_rst_data", 32'(bus.data_out), 32'd0);
        check("s6_rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        chk_en = 1'b1;
        repeat (300) @(posedge clk);
        check_pulses("s6b");
        send_frame(8'h1A, 0, 0);
        #1;
        check("s6_word", 32'(bus.data_out), 32'h01A);
        pop();
        repeat (5) @(posedge clk);
        check_pulses("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
